// File: rtl/alu_issue_wb_pkg.sv
// Shared CPU data definitions: ALU operator codes, flag bit positions, issue-stage state encoding.
// Two-operand and single-operand groups reuse codes 0-7; alu_single selects the group.
package alu_issue_wb_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;

    localparam logic [3:0] OP_NEG = 4'd0;
    localparam logic [3:0] OP_COM = 4'd1;
    localparam logic [3:0] OP_LSL = 4'd2;
    localparam logic [3:0] OP_LSR = 4'd3;
    localparam logic [3:0] OP_ROL = 4'd4;
    localparam logic [3:0] OP_ROR = 4'd5;
    localparam logic [3:0] OP_RLC = 4'd6;
    localparam logic [3:0] OP_RRC = 4'd7;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Compares only set flags; every other operator retires its result.
    function automatic logic writes_back(input logic [3:0] op);
        return op != OP_CMP;
    endfunction

endpackage

// File: rtl/alu_issue_wb_regfile.sv
// General register file: two async read ports, one sync write port, debug read port.
// Latency: reads combinational, write visible after the clock edge. No backpressure.
// Reset clears every entry.
module alu_regfile #(
    parameter int NREGS  = 8,
    parameter int RIDX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RIDX_W-1:0] rd1_idx,
    output logic [7:0]        rd1_dat,
    input  logic [RIDX_W-1:0] rd2_idx,
    output logic [7:0]        rd2_dat,
    input  logic              wr_en,
    input  logic [RIDX_W-1:0] wr_idx,
    input  logic [7:0]        wr_dat,
    input  logic [RIDX_W-1:0] dbg_idx,
    output logic [7:0]        dbg_data
);

    logic [7:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_dat;
        end
    end

    assign rd1_dat  = regs[rd1_idx];
    assign rd2_dat  = regs[rd2_idx];
    assign dbg_data = regs[dbg_idx];

endmodule

// File: rtl/alu_issue_wb.sv
// Execute-stage sequencer around the 8-bit ALU: IDLE -> EXEC -> WB, one instruction per 2 cycles.
// Latency: accept edge to register writeback is 3 edges; in_ready drops only during EXEC, no stalls.
// Optional immediate operand path enabled by ALU_ISSUE_IMM_EN.
module alu_issue_wb
    import alu_issue_wb_pkg::*;
#(
    parameter int NREGS  = 8,
    parameter int RIDX_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic              in_single,
    input  logic [RIDX_W-1:0] in_dst,
    input  logic [RIDX_W-1:0] in_src,
`ifdef ALU_ISSUE_IMM_EN
    input  logic              in_imm_sel,
    input  logic [7:0]        in_imm,
`endif
    output logic [7:0]        alu_value1,
    output logic [7:0]        alu_value2,
    output logic [3:0]        alu_operator,
    output logic              alu_single,
    output logic              alu_old_carry,
    input  logic [7:0]        alu_result,
    input  logic [3:0]        alu_flags_in,
    output logic [3:0]        flags,
    output logic              wb_valid,
    input  logic [RIDX_W-1:0] dbg_idx,
    output logic [7:0]        dbg_data
);

    state_t            state;
    logic [3:0]        op_q;
    logic              single_q;
    logic [RIDX_W-1:0] dst_q;
    logic [RIDX_W-1:0] src_q;
    logic [7:0]        v1_hold;
    logic [7:0]        v2_hold;
    logic [7:0]        rd1_dat;
    logic [7:0]        rd2_dat;
    logic [7:0]        src_val;
    logic              accept;
    logic              exec_now;
    logic              wr_en;

`ifdef ALU_ISSUE_IMM_EN
    logic [7:0]        imm_q;
    logic              imm_sel_q;
    assign src_val = imm_sel_q ? imm_q : rd2_dat;
`else
    assign src_val = rd2_dat;
`endif

    assign accept   = in_valid && in_ready;
    assign exec_now = (state == EXEC);
    assign wr_en    = (state == WB) && writes_back(op_q);

    // Operands are read live in EXEC so the previous WB write is already visible.
    assign alu_value1    = exec_now ? rd1_dat : v1_hold;
    assign alu_value2    = exec_now ? (single_q ? 8'h00 : src_val) : v2_hold;
    assign alu_operator  = op_q;
    assign alu_single    = single_q;
    assign alu_old_carry = flags[FLAG_C];

    alu_regfile #(
        .NREGS  (NREGS),
        .RIDX_W (RIDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd1_idx  (dst_q),
        .rd1_dat  (rd1_dat),
        .rd2_idx  (src_q),
        .rd2_dat  (rd2_dat),
        .wr_en    (wr_en),
        .wr_idx   (dst_q),
        .wr_dat   (alu_result),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            wb_valid <= 1'b0;
            flags    <= 4'h0;
            op_q     <= 4'h0;
            single_q <= 1'b0;
            dst_q    <= '0;
            src_q    <= '0;
            v1_hold  <= 8'h00;
            v2_hold  <= 8'h00;
`ifdef ALU_ISSUE_IMM_EN
            imm_q     <= 8'h00;
            imm_sel_q <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
            if (accept) begin
                op_q     <= in_op;
                single_q <= in_single;
                dst_q    <= in_dst;
                src_q    <= in_src;
`ifdef ALU_ISSUE_IMM_EN
                imm_q     <= in_imm;
                imm_sel_q <= in_imm_sel && !in_single;
`endif
            end
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= EXEC;
                        in_ready <= 1'b0;
                    end
                end
                EXEC: begin
                    v1_hold  <= alu_value1;
                    v2_hold  <= alu_value2;
                    state    <= WB;
                    in_ready <= 1'b1;
                    wb_valid <= 1'b1;
                end
                WB: begin
                    flags <= alu_flags_in;
                    if (in_valid) begin
                        state    <= EXEC;
                        in_ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Scoreboard bench for alu_issue_wb with a behavioural ALU fixture and register-file reference model.
module tb_alu_issue_wb;
    import alu_issue_wb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_op = 4'h0;
    logic       in_single = 1'b0;
    logic [2:0] in_dst = 3'd0;
    logic [2:0] in_src = 3'd0;
    logic [7:0] alu_value1, alu_value2;
    logic [3:0] alu_operator;
    logic       alu_single, alu_old_carry;
    logic [7:0] alu_result = 8'h00;
    logic [3:0] alu_flags_in = 4'h0;
    logic [3:0] flags;
    logic       wb_valid;
    logic [2:0] dbg_idx = 3'd0;
    logic [7:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_wb #(.NREGS(8), .RIDX_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_single(in_single), .in_dst(in_dst), .in_src(in_src),
`ifdef ALU_ISSUE_IMM_EN
        .in_imm_sel(1'b0), .in_imm(8'h00),
`endif
        .alu_value1(alu_value1), .alu_value2(alu_value2), .alu_operator(alu_operator),
        .alu_single(alu_single), .alu_old_carry(alu_old_carry), .alu_result(alu_result),
        .alu_flags_in(alu_flags_in), .flags(flags), .wb_valid(wb_valid),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int sweep_cnt = 0;
    bit sweep_req = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Behavioural ALU: returns {C,V,Z,N, result}.
    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic sgl,
                                           input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        w = 9'h000; c = 1'b0; v = 1'b0;
        if (!sgl) begin
            case (op)
                OP_ADD: w = {1'b0, a} + {1'b0, b};
                OP_ADC: w = {1'b0, a} + {1'b0, b} + {8'h00, cin};
                OP_SUB, OP_CMP: w = {1'b0, a} - {1'b0, b};
                OP_SBC: w = {1'b0, a} - {1'b0, b} - {8'h00, cin};
                OP_AND: w = {1'b0, a & b};
                OP_OR:  w = {1'b0, a | b};
                OP_XOR: w = {1'b0, a ^ b};
                OP_MOV: w = {1'b0, b};
                default: w = 9'h000;
            endcase
            r = w[7:0];
            if (op == OP_ADD || op == OP_ADC) begin
                c = w[8]; v = (a[7] == b[7]) && (r[7] != a[7]);
            end else if (op == OP_SUB || op == OP_SBC || op == OP_CMP) begin
                c = w[8]; v = (a[7] != b[7]) && (r[7] != a[7]);
            end
        end else begin
            case (op)
                OP_NEG: begin r = 8'h00 - a; c = (a != 8'h00); v = (a == 8'h80); end
                OP_COM: r = ~a;
                OP_LSL: begin r = {a[6:0], 1'b0}; c = a[7]; end
                OP_LSR: begin r = {1'b0, a[7:1]}; c = a[0]; end
                OP_ROL: begin r = {a[6:0], a[7]}; c = a[7]; end
                OP_ROR: begin r = {a[0], a[7:1]}; c = a[0]; end
                OP_RLC: begin r = {a[6:0], cin};  c = a[7]; end
                OP_RRC: begin r = {cin, a[7:1]};  c = a[0]; end
                default: r = 8'h00;
            endcase
        end
        return {c, v, (r == 8'h00), r[7], r};
    endfunction

    // ALU fixture: registered, computes every cycle; a per-instruction override seeds register values.
    logic       ovr_en = 1'b0, ovr_q = 1'b0;
    logic [7:0] ovr_val = 8'h00, ovr_val_q = 8'h00;
    logic [3:0] ovr_fl = 4'h0, ovr_fl_q = 4'h0;
    logic [11:0] alu_now;
    assign alu_now = alu_fn(alu_operator, alu_single, alu_value1, alu_value2, alu_old_carry);

    always @(posedge clk) begin
        if (in_valid && in_ready) begin
            ovr_q     <= ovr_en;
            ovr_val_q <= ovr_val;
            ovr_fl_q  <= ovr_fl;
        end
        alu_result   <= ovr_q ? ovr_val_q : alu_now[7:0];
        alu_flags_in <= ovr_q ? ovr_fl_q : alu_now[11:8];
    end

    // Reference architectural state, updated in issue order.
    logic [7:0] mregs [8];
    logic [3:0] mflags;

    typedef struct {
        logic [2:0] dst;
        logic [7:0] v1, v2;
        logic [3:0] op;
        logic       sgl, cin;
        logic [7:0] newv;
        logic [3:0] fl;
    } exp_t;
    exp_t exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mregs[i] = 8'h00;
        mflags = 4'h0;
    endtask

    task automatic issue(input logic [3:0] op, input logic sgl, input logic [2:0] d, input logic [2:0] s,
                         input logic oe, input logic [7:0] ov, input logic [3:0] of,
                         input bit push, output int acc);
        int n;
        exp_t e;
        logic [11:0] r;
        in_valid = 1'b1; in_op = op; in_single = sgl; in_dst = d; in_src = s;
        ovr_en = oe; ovr_val = ov; ovr_fl = of;
        n = 0;
        while (!in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", 8'h00, 8'h01);
        @(posedge clk);
        acc = cyc;
        if (push) begin
            e.dst = d; e.op = op; e.sgl = sgl; e.cin = mflags[3];
            e.v1 = mregs[d];
            e.v2 = sgl ? 8'h00 : mregs[s];
            r = oe ? {of, ov} : alu_fn(op, sgl, e.v1, e.v2, e.cin);
            e.newv = (op == OP_CMP) ? e.v1 : r[7:0];
            e.fl = r[11:8];
            mregs[d] = e.newv;
            mflags = e.fl;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        ovr_en = 1'b0;
    endtask

    task automatic load(input logic [2:0] d, input logic [7:0] val);
        int acc;
        issue(OP_MOV, 1'b0, d, 3'd0, 1'b1, val, 4'h0, 1'b1, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 8'(exp_q.size()), 8'h00);
        repeat (2) @(negedge clk);
    endtask

    task automatic sweep();
        int s0 = sweep_cnt;
        int n = 0;
        sweep_req = 1'b1;
        while (sweep_cnt == s0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sweep_cnt == s0) chk("sweep_timeout", 8'h00, 8'h01);
        sweep_req = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per retiring instruction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_wb", 8'h01, 8'h00);
                end else begin
                    e = exp_q.pop_front();
                    chk("alu_value1", alu_value1, e.v1);
                    chk("alu_value2", alu_value2, e.v2);
                    chk("alu_operator", 8'(alu_operator), 8'(e.op));
                    chk("alu_single", 8'(alu_single), 8'(e.sgl));
                    chk("alu_old_carry", 8'(alu_old_carry), 8'(e.cin));
                    dbg_idx = e.dst;
                    #1;
                    chk("reg_before_wb", dbg_data, e.v1);
                    @(negedge clk);
                    chk("wb_pulse_width", 8'(wb_valid), 8'h00);
                    chk("reg_after_wb", dbg_data, e.newv);
                    chk("flags_after_wb", 8'(flags), 8'(e.fl));
                end
            end else if (sweep_req) begin
                for (int i = 0; i < 8; i++) begin
                    dbg_idx = 3'(i);
                    #1;
                    chk("sweep_reg", dbg_data, mregs[i]);
                end
                sweep_cnt++;
            end
        end
    end

    initial begin
        int a0, a1, acc4[4];
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 8'(in_ready), 8'h01);
        chk("rst_wb_valid", 8'(wb_valid), 8'h00);
        chk("rst_flags", 8'(flags), 8'h00);
        chk("rst_alu_value1", alu_value1, 8'h00);
        chk("rst_alu_value2", alu_value2, 8'h00);
        chk("rst_alu_operator", 8'(alu_operator), 8'h00);
        chk("rst_alu_single", 8'(alu_single), 8'h00);
        chk("rst_dbg_data", dbg_data, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // MOV from a preloaded register.
        load(3'd2, 8'h5A);
        issue(OP_MOV, 1'b0, 3'd1, 3'd2, 1'b0, 8'h00, 4'h0, 1'b1, a0);
        drain();

        // ADD overflowing into the sign bit.
        load(3'd1, 8'h7F);
        load(3'd2, 8'h01);
        issue(OP_ADD, 1'b0, 3'd1, 3'd2, 1'b0, 8'h00, 4'h0, 1'b1, a0);
        drain();
        chk("add_flags", 8'(flags), 8'h05);

        // CMP leaves the destination alone.
        load(3'd3, 8'h10);
        load(3'd4, 8'h10);
        issue(OP_CMP, 1'b0, 3'd3, 3'd4, 1'b0, 8'h00, 4'h0, 1'b1, a0);
        drain();
        chk("cmp_flags", 8'(flags), 8'h02);

        // Carry chains from LSL into a back-to-back RLC.
        load(3'd5, 8'h80);
        load(3'd6, 8'h01);
        drain();
        chk("b2b_ready_idle", 8'(in_ready), 8'h01);
        issue(OP_LSL, 1'b1, 3'd5, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, a0);
        chk("b2b_ready_exec", 8'(in_ready), 8'h00);
        @(negedge clk);
        chk("b2b_ready_wb", 8'(in_ready), 8'h01);
        issue(OP_RLC, 1'b1, 3'd6, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, a1);
        chk("b2b_gap", 8'(a1 - a0), 8'd2);
        drain();
        sweep();

        // Reset during EXEC abandons the instruction.
        load(3'd7, 8'h33);
        drain();
        issue(OP_ADD, 1'b0, 3'd7, 3'd7, 1'b0, 8'h00, 4'h0, 1'b0, a0);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 8'(in_ready), 8'h01);
        chk("midrst_flags", 8'(flags), 8'h00);
        chk("midrst_wb_valid", 8'(wb_valid), 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(OP_MOV, 1'b0, 3'd0, 3'd7, 1'b0, 8'h00, 4'h0, 1'b1, a0);
        drain();

        // Four instructions with in_valid held high.
        load(3'd1, 8'h11);
        load(3'd2, 8'h22);
        drain();
        issue(OP_ADD, 1'b0, 3'd3, 3'd1, 1'b0, 8'h00, 4'h0, 1'b1, acc4[0]);
        issue(OP_XOR, 1'b0, 3'd4, 3'd2, 1'b0, 8'h00, 4'h0, 1'b1, acc4[1]);
        issue(OP_SUB, 1'b0, 3'd3, 3'd4, 1'b0, 8'h00, 4'h0, 1'b1, acc4[2]);
        issue(OP_NEG, 1'b1, 3'd4, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, acc4[3]);
        for (int i = 1; i < 4; i++) chk("stream_gap", 8'(acc4[i] - acc4[i-1]), 8'd2);
        drain();
        sweep();

        // Randomized traffic.
        for (int k = 0; k < 60; k++) begin
            int gap = $urandom_range(0, 2);
            int kind = $urandom_range(0, 9);
            logic sgl;
            repeat (gap) @(negedge clk);
            if (kind < 3) begin
                load(3'($urandom_range(0, 7)), 8'($urandom));
            end else begin
                sgl = 1'($urandom_range(0, 1));
                issue(sgl ? 4'($urandom_range(0, 7)) : 4'($urandom_range(0, 8)), sgl,
                      3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      1'b0, 8'h00, 4'h0, 1'b1, a0);
            end
        end
        drain();
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Execute-stage sequencer that sits directly around the 8-bit ALU.
- Accepts decoded ALU instructions over a valid/ready handshake and reads operands from an internal 8x8 register file.
- Drives the ALU operand, operator and mode inputs for one clock, then writes the registered ALU result and flags back.
- Holds the architectural flags register; its carry bit feeds the ALU carry-in for ADC/SBC/RLC/RRC.

Parameters:
- NREGS, 8, number of 8-bit general registers; must be a power of two.
- RIDX_W, 3, register index width, equal to log2(NREGS).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept an instruction this cycle.
- in_op  in  4  ALU operator code; uses the shared OP_* encodings.
- in_single  in  1  1 = single-operand group (NEG/COM/LSL/LSR/ROL/ROR/RLC/RRC).
- in_dst  in  RIDX_W  destination register; also supplies operand 1.
- in_src  in  RIDX_W  source register; supplies operand 2.
- alu_value1  out  8  ALU operand 1.
- alu_value2  out  8  ALU operand 2.
- alu_operator  out  4  ALU operator.
- alu_single  out  1  ALU mode select.
- alu_old_carry  out  1  carry-in, equal to flags[3].
- alu_result  in  8  registered ALU result.
- alu_flags_in  in  4  registered ALU flags {C,V,Z,N}.
- flags  out  4  architectural flags {C,V,Z,N}.
- wb_valid  out  1  one-cycle pulse when a result retires.
- dbg_idx  in  RIDX_W  debug register-read index.
- dbg_data  out  8  combinational register-file read at dbg_idx.

Behaviour:
- Reset (async assert, sync release): state IDLE; all registers and flags = 0; alu_* outputs = 0; wb_valid = 0; in_ready = 1.
- States:
  - IDLE: in_ready = 1. On in_valid, latch op, single, dst and src, then go to EXEC.
  - EXEC: in_ready = 0. Drive alu_value1 = R[dst], alu_value2 = R[src] (0 when single), alu_operator = op, alu_single = single. The ALU samples these at the end of this cycle. Next state is WB.
  - WB: in_ready = 1, wb_valid = 1. R[dst] <= alu_result unless op == OP_CMP. flags <= alu_flags_in for every op. If in_valid, latch the new instruction and go to EXEC; otherwise go to IDLE.
- Throughput is one instruction per 2 cycles. Latency from accept edge to R[dst] update is 3 edges.
- Read-after-write is safe: the EXEC operand read always follows the WB write of the previous instruction.
- alu_* outputs hold their last values outside EXEC. The ALU computes every cycle, but only the value present in WB is consumed.
- alu_old_carry = flags[3] combinationally. It is stable through EXEC because flags change only in WB.
- in_* inputs are ignored while in_ready = 0; no stalling is required.
- dst == src is legal and reads the same register for both operands.
- Reset asserted mid-instruction abandons it; no writeback occurs.

Optional Feature:
- Macro ALU_ISSUE_IMM_EN.
- When defined:
  - Extra input in_imm_sel (1) and in_imm (8) are present.
  - When in_imm_sel = 1 and in_single = 0, in_imm is latched at accept and drives alu_value2 in place of R[src].
- When undefined: those ports are absent and alu_value2 always comes from the register file.

Decomposition:
- The OP_* operator encodings and flag bit positions (C=3, V=2, Z=1, N=0) stay in the shared cpu data package. The state encoding constants IDLE/EXEC/WB belong there too.
- Natural sub-module: alu_regfile (two async read ports, one sync write port, async active-low reset clearing all entries, plus the debug read port).

Test Plan:
- Reset, then issue OP_MOV dst=1 with immediate 0x5A (IMM_EN build), or via a pre-loaded register → R1 = 0x5A at the third edge after accept; wb_valid pulses for exactly one cycle.
- R1 = 0x7F, R2 = 0x01, OP_ADD dst=1 src=2 → R1 = 0x80; flags = the ALU-reported {C,V,Z,N}, with C=0 and N=1.
- R3 = 0x10, R4 = 0x10, OP_CMP dst=3 src=4 → R3 unchanged at 0x10; flags updated; wb_valid = 1.
- OP_LSL on R5 = 0x80 (sets C=1), then OP_RLC on R6 = 0x01 issued back-to-back in the WB cycle → alu_old_carry = 1 during the RLC EXEC; R6 = 0x03; in_ready is 1, 0, 1 across consecutive cycles.
- Assert rst_n low during EXEC of OP_ADD → no register write, flags = 0, state IDLE, in_ready = 1 immediately.
- Hold in_valid high continuously with 4 instructions → accepted on edges 1, 3, 5, 7 (exactly 2-cycle spacing); all four results are correct in dbg_data reads.
